// File: rtl/imem_pkg.sv
// Shared types, default parameters and packed-bus lane helpers for the
// multi-port instruction memory.
package imem_pkg;

    // Controller states: FILL while the array is being initialised, RUN after.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } imem_state_e;

    localparam int          DEF_DATA_WIDTH = 16;
    localparam int          DEF_ADDR_WIDTH = 6;
    localparam int          DEF_NUM_RD     = 2;
    localparam int          DEF_NUM_WR     = 2;
    localparam logic [15:0] DEF_FILL_VALUE = 16'h0100;

    // Low bit of lane `lane` in a packed bus of `width`-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/imem_fill_ctrl.sv
// FILL/RUN sequencer: walks fill_addr across the whole array after reset,
// raises ready when the last word is written, and latches any write attempt
// made before then into the sticky wr_dropped flag.
module imem_fill_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_attempt,
    output logic                  fill_we,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic                  ready,
    output logic                  wr_dropped,
    output imem_state_e           state
);

    imem_state_e           state_next;
    logic [ADDR_WIDTH-1:0] fill_addr_next;
    logic                  wr_dropped_next;

    // State, fill pointer and sticky drop flag; reset restarts the fill at 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FILL;
            fill_addr  <= '0;
            wr_dropped <= 1'b0;
        end else begin
            state      <= state_next;
            fill_addr  <= fill_addr_next;
            wr_dropped <= wr_dropped_next;
        end
    end

    // Next-state: advance the fill pointer, leave FILL after the top address.
    always_comb begin
        state_next      = state;
        fill_addr_next  = fill_addr;
        wr_dropped_next = wr_dropped;
        fill_we         = 1'b0;
        case (state)
            FILL: begin
                fill_we        = 1'b1;
                fill_addr_next = fill_addr + 1'b1;
                if (wr_attempt) begin
                    wr_dropped_next = 1'b1;
                end
                if (&fill_addr) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    assign ready = (state == RUN);

endmodule

// File: rtl/instruction_memory_mp.sv
// Multi-port instruction memory: NUM_WR write ports with highest-index-wins
// collision resolution, NUM_RD read ports (combinational or registered with
// optional write-first bypass), and a post-reset fill to FILL_VALUE.
module instruction_memory_mp
    import imem_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    NUM_RD     = DEF_NUM_RD,
    parameter int                    NUM_WR     = DEF_NUM_WR,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = DATA_WIDTH'(DEF_FILL_VALUE),
    parameter bit                    READ_REG   = 1'b0,
    parameter bit                    BYPASS     = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_WR-1:0]            wr_en,
    output logic                         ready,
    output logic                         wr_collision,
    output logic                         wr_dropped
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_addr_l [NUM_RD];
    logic [ADDR_WIDTH-1:0] wr_addr_l [NUM_WR];
    logic [DATA_WIDTH-1:0] wr_data_l [NUM_WR];

    logic                  fill_we;
    logic [ADDR_WIDTH-1:0] fill_addr;
    imem_state_e           fill_state;
    logic                  run;
    logic                  collide;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
        assign rd_addr_l[i] = rd_addr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
    end

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_unpack
        assign wr_addr_l[p] = wr_addr[lane_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];
        assign wr_data_l[p] = wr_data[lane_lo(p, DATA_WIDTH) +: DATA_WIDTH];
    end

    imem_fill_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fill_ctrl (
        .clock      (clock),
        .reset      (reset),
        .wr_attempt (|wr_en),
        .fill_we    (fill_we),
        .fill_addr  (fill_addr),
        .ready      (ready),
        .wr_dropped (wr_dropped),
        .state      (fill_state)
    );

    assign run = (fill_state == RUN);

    // Any pair of enabled write ports aimed at the same word.
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_en[i] && wr_en[j] && (wr_addr_l[i] == wr_addr_l[j])) begin
                    collide = 1'b1;
                end
            end
        end
    end

    // One-cycle collision pulse for each colliding RUN edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= run && collide;
        end
    end

    // Array writes: fill word in FILL, user ports in RUN; later ports override
    // earlier ones on the same word so the highest enabled index wins.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (fill_we) begin
                mem[fill_addr] <= FILL_VALUE;
            end else if (run) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p]) begin
                        mem[wr_addr_l[p]] <= wr_data_l[p];
                    end
                end
            end
        end
    end

    if (READ_REG) begin : g_reg_read
        logic [DATA_WIDTH-1:0] rd_q    [NUM_RD];
        logic [DATA_WIDTH-1:0] rd_next [NUM_RD];

        // Per-lane read value for the next edge, with write-first forwarding.
        always_comb begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_next[i] = FILL_VALUE;
                if (ready) begin
                    rd_next[i] = mem[rd_addr_l[i]];
                    if (BYPASS) begin
                        for (int p = 0; p < NUM_WR; p++) begin
                            if (wr_en[p] && (wr_addr_l[p] == rd_addr_l[i])) begin
                                rd_next[i] = wr_data_l[p];
                            end
                        end
                    end
                end
            end
        end

        // Read data register; reset loads the fill word on every lane.
        always_ff @(posedge clock) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_q[i] <= reset ? FILL_VALUE : rd_next[i];
            end
        end

        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_pack
            assign rd_data[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = rd_q[i];
        end
    end else begin : g_comb_read
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_pack
            assign rd_data[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
                ready ? mem[rd_addr_l[i]] : FILL_VALUE;
        end
    end

endmodule

// File: tb/tb_instruction_memory_mp.sv
// Bench for instruction_memory_mp: three instances (combinational read,
// registered+bypass, registered without bypass) share one stimulus stream and
// are compared every edge against a word-level reference model.
module tb_instruction_memory_mp;

    localparam int          DW    = 16;
    localparam int          AW    = 6;
    localparam int          NR    = 2;
    localparam int          NW    = 2;
    localparam int          DEPTH = 64;
    localparam logic [15:0] FV    = 16'h0100;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [NR*AW-1:0] rd_addr = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*DW-1:0] wr_data = '0;
    logic [NW-1:0]    wr_en   = '0;

    logic [NR*DW-1:0] rd_data_c, rd_data_b, rd_data_n;
    logic ready_c, ready_b, ready_n;
    logic coll_c, coll_b, coll_n;
    logic drop_c, drop_b, drop_n;

    // Clock
    always #5 clock = ~clock;

    instruction_memory_mp #(.READ_REG(1'b0), .BYPASS(1'b1)) dut_c (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_c),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .ready(ready_c), .wr_collision(coll_c), .wr_dropped(drop_c)
    );

    instruction_memory_mp #(.READ_REG(1'b1), .BYPASS(1'b1)) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .ready(ready_b), .wr_collision(coll_b), .wr_dropped(drop_b)
    );

    instruction_memory_mp #(.READ_REG(1'b1), .BYPASS(1'b0)) dut_n (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .ready(ready_n), .wr_collision(coll_n), .wr_dropped(drop_n)
    );

    // Scoreboard counters
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: word array plus "edges since reset" fill counter.
    logic [15:0] m_mem   [DEPTH];
    logic [15:0] m_reg_b [NR];
    logic [15:0] m_reg_n [NR];
    int          m_cnt     = 0;
    bit          m_ready   = 1'b0;
    bit          m_dropped = 1'b0;
    bit          m_coll    = 1'b0;

    function automatic logic [AW-1:0] ra(input int i);
        return rd_addr[i*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] wa(input int p);
        return wr_addr[p*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wd(input int p);
        return wr_data[p*DW +: DW];
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_cnt     = 0;
            m_ready   = 1'b0;
            m_dropped = 1'b0;
            m_coll    = 1'b0;
            for (int i = 0; i < NR; i++) begin
                m_reg_b[i] = FV;
                m_reg_n[i] = FV;
            end
        end else if (!m_ready) begin
            for (int i = 0; i < NR; i++) begin
                m_reg_b[i] = FV;
                m_reg_n[i] = FV;
            end
            if (wr_en != '0) m_dropped = 1'b1;
            m_coll = 1'b0;
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int a = 0; a < DEPTH; a++) m_mem[a] = FV;
            end
        end else begin
            for (int i = 0; i < NR; i++) begin
                m_reg_n[i] = m_mem[ra(i)];
                m_reg_b[i] = m_mem[ra(i)];
                for (int p = 0; p < NW; p++) begin
                    if (wr_en[p] && wa(p) == ra(i)) m_reg_b[i] = wd(p);
                end
            end
            m_coll = 1'b0;
            for (int p = 0; p < NW; p++) begin
                for (int q = p + 1; q < NW; q++) begin
                    if (wr_en[p] && wr_en[q] && wa(p) == wa(q)) m_coll = 1'b1;
                end
            end
            for (int p = 0; p < NW; p++) begin
                if (wr_en[p]) m_mem[wa(p)] = wd(p);
            end
        end
    endtask

    task automatic check_all();
        check("c_ready", ready_c, m_ready);
        check("b_ready", ready_b, m_ready);
        check("n_ready", ready_n, m_ready);
        check("c_coll", coll_c, m_coll);
        check("b_coll", coll_b, m_coll);
        check("n_coll", coll_n, m_coll);
        check("c_drop", drop_c, m_dropped);
        check("b_drop", drop_b, m_dropped);
        check("n_drop", drop_n, m_dropped);
        for (int i = 0; i < NR; i++) begin
            logic [15:0] exp_c;
            exp_c = m_ready ? m_mem[ra(i)] : FV;
            check($sformatf("comb_rd%0d", i), rd_data_c[i*DW +: DW], exp_c);
            check($sformatf("regb_rd%0d", i), rd_data_b[i*DW +: DW], m_reg_b[i]);
            check($sformatf("regn_rd%0d", i), rd_data_n[i*DW +: DW], m_reg_n[i]);
        end
    endtask

    // Driver: one clock edge, model update at the edge, sample 1 ns later.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        wr_en = '0;
    endtask

    initial begin
        int edges;

        // Reset for one edge
        reset = 1'b1;
        idle();
        tick();
        check("rst_ready", ready_c, 1'b0);
        check("rst_coll", coll_b, 1'b0);
        check("rst_drop", drop_n, 1'b0);
        check("rst_regb_rd0", rd_data_b[15:0], FV);
        check("rst_regn_rd1", rd_data_n[31:16], FV);
        reset = 1'b0;

        // Fill, with a dropped write at fill cycle 10
        edges = 0;
        for (int e = 0; e < 200 && !ready_c; e++) begin
            idle();
            rd_addr = NR*AW'($urandom);
            if (e == 10) begin
                wr_en         = 2'b01;
                wr_addr[5:0]  = 6'd3;
                wr_data[15:0] = 16'hBEEF;
            end
            tick();
            edges++;
        end
        check("fill_latency", edges, 64);
        check("drop_after_fill", drop_c, 1'b1);

        // Every word reads the fill value
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            rd_addr = {6'(63 - a), 6'(a)};
            tick();
            check("fill_word", rd_data_c[15:0], FV);
        end
        check("drop_sticky", drop_b, 1'b1);

        // Parallel write to different words
        wr_en   = 2'b11;
        wr_addr = {6'd9, 6'd5};
        wr_data = {16'h1234, 16'hABCD};
        rd_addr = {6'd9, 6'd5};
        tick();
        check("par_coll_edge", coll_c, 1'b0);
        check("par_rd0", rd_data_c[15:0], 16'hABCD);
        check("par_rd1", rd_data_c[31:16], 16'h1234);
        check("par_byp_rd0", rd_data_b[15:0], 16'hABCD);
        idle();
        tick();
        check("par_coll", coll_c, 1'b0);
        check("par_reg_rd1", rd_data_n[31:16], 16'h1234);

        // Same-address collision
        wr_en   = 2'b11;
        wr_addr = {6'd7, 6'd7};
        wr_data = {16'h2222, 16'h1111};
        rd_addr = {6'd7, 6'd7};
        tick();
        check("coll_pulse", coll_c, 1'b1);
        check("coll_word", rd_data_c[15:0], 16'h2222);
        idle();
        tick();
        check("coll_end", coll_c, 1'b0);
        check("coll_reg_word", rd_data_n[15:0], 16'h2222);

        // Registered read with and without bypass
        wr_en         = 2'b01;
        wr_addr[5:0]  = 6'd12;
        wr_data[15:0] = 16'h5A5A;
        rd_addr       = {6'd3, 6'd12};
        tick();
        check("bypass_rd0", rd_data_b[15:0], 16'h5A5A);
        check("nobypass_rd0", rd_data_n[15:0], FV);
        check("dropped_word3", rd_data_c[31:16], FV);
        idle();

        // Random traffic over a narrow address window, with rare resets
        for (int k = 0; k < 400; k++) begin
            reset   = ($urandom_range(0, 199) == 0);
            wr_en   = NW'($urandom);
            wr_addr = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            wr_data = {16'($urandom), 16'($urandom)};
            rd_addr = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            tick();
        end

        // Reset in the middle of a fill restarts the full count
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 0; e < 30; e++) tick();
        check("midfill_not_ready", ready_c, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        edges = 0;
        for (int e = 0; e < 200 && !ready_c; e++) begin
            rd_addr = NR*AW'($urandom);
            tick();
            edges++;
        end
        check("refill_latency", edges, 64);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
